snake_move_engine: RTL

Movement and collision engine for the snake game. On each move-enable pulse from the game state machine, it advances the snake one cell in the requested direction and checks wall and self collision. It then grows the body when food is eaten and updates the score. It is the stage directly upstream of the game state machine: its DEAD, SCORE and DONE outputs feed that block, and its body query port is read by the renderer.

---
 rtl/snake_pkg.sv | 31 +++
 rtl/snake_body_store.sv | 75 +++++++
 rtl/snake_move_engine.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake movement engine: direction codes, FSM states, grid defaults.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package snake_pkg;

  localparam int DEF_GRID_W   = 32;
  localparam int DEF_GRID_H   = 24;
  localparam int DEF_MAX_LEN  = 16;
  localparam int DEF_INIT_LEN = 3;
  localparam int DEF_XW       = 5;
  localparam int DEF_YW       = 5;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_CHECK,
    ST_COMMIT,
    ST_FIN
  } state_t;

  // Up/down and left/right differ only in bit 0, so the reverse flips that bit.
  function automatic logic [1:0] rev_dir(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/snake_body_store.sv
// Snake body segment array: restart load, shift-and-insert on commit, scan read port, query compare.
// Latency: writes land on the next edge; scan read and query outputs are combinational.
// Backpressure: none; load has priority over push, caller guarantees push only on a committed move.
module snake_body_store
  import snake_pkg::*;
#(
  parameter int GRID_W  = DEF_GRID_W,
  parameter int GRID_H  = DEF_GRID_H,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int LW      = $clog2(MAX_LEN + 1),
  parameter int IW      = $clog2(MAX_LEN)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_push,
  input  logic [XW-1:0] i_push_x,
  input  logic [YW-1:0] i_push_y,
  input  logic [LW-1:0] i_len,
  input  logic [IW-1:0] i_rd_idx,
  output logic [XW-1:0] o_rd_x,
  output logic [YW-1:0] o_rd_y,
  output logic [XW-1:0] o_head_x,
  output logic [YW-1:0] o_head_y,
  input  logic [XW-1:0] i_qx,
  input  logic [YW-1:0] i_qy,
  output logic          o_qhit,
  output logic          o_qhead
);

  logic [XW-1:0] r_seg_x [MAX_LEN];
  logic [YW-1:0] r_seg_y [MAX_LEN];

  // Segment array: horizontal restart line on reset/restart, shift-and-insert on a committed move.
  // Every slot is loaded so segments that become live through growth already hold valid cells.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= XW'(GRID_W / 2 - i);
        r_seg_y[i] <= YW'(GRID_H / 2);
      end
    end else if (i_load) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= XW'(GRID_W / 2 - i);
        r_seg_y[i] <= YW'(GRID_H / 2);
      end
    end else if (i_push) begin
      r_seg_x[0] <= i_push_x;
      r_seg_y[0] <= i_push_y;
      for (int i = 1; i < MAX_LEN; i++) begin
        r_seg_x[i] <= r_seg_x[i-1];
        r_seg_y[i] <= r_seg_y[i-1];
      end
    end
  end

  assign o_rd_x   = r_seg_x[i_rd_idx];
  assign o_rd_y   = r_seg_y[i_rd_idx];
  assign o_head_x = r_seg_x[0];
  assign o_head_y = r_seg_y[0];
  assign o_qhead  = (r_seg_x[0] == i_qx) && (r_seg_y[0] == i_qy);

  // Renderer query: hit if any live segment (index below current length) sits on the query cell.
  always_comb begin
    o_qhit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < i_len) && (r_seg_x[i] == i_qx) && (r_seg_y[i] == i_qy)) begin
        o_qhit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_move_engine.sv
// Snake movement/collision engine: one move per EN pulse with wall/self checks, growth and scoring.
// Latency: EN to DONE is LEN+3 cycles (LEN before the move); 1 cycle when already dead.
// Backpressure: none; EN outside IDLE is dropped, RST restarts immediately and wins over EN.
module snake_move_engine
  import snake_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int INIT_LEN = DEF_INIT_LEN,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  localparam int LW      = $clog2(MAX_LEN + 1),
  localparam int IW      = $clog2(MAX_LEN)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [1:0]    i_dir,
  input  logic [XW-1:0] i_food_x,
  input  logic [YW-1:0] i_food_y,
  input  logic          i_food_valid,
  input  logic [XW-1:0] i_qx,
  input  logic [YW-1:0] i_qy,
  output logic          o_qhit,
  output logic          o_qhead,
  output logic [XW-1:0] o_head_x,
  output logic [YW-1:0] o_head_y,
  output logic [LW-1:0] o_len,
  output logic [7:0]    o_score,
  output logic          o_dead,
  output logic          o_eat,
  output logic          o_done
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_dir;
  logic [XW-1:0] r_nx;
  logic [YW-1:0] r_ny;
  logic          r_grow;
  logic          r_dead_pend;
  logic [LW-1:0] r_idx;
  logic [LW-1:0] r_len;
  logic [7:0]    r_score;
  logic          r_dead;
  logic          r_eat;
  logic          r_done;

  logic [XW-1:0] w_head_x;
  logic [YW-1:0] w_head_y;
  logic [XW-1:0] w_rd_x;
  logic [YW-1:0] w_rd_y;
  logic          w_push;
  logic [1:0]    w_dir;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_wall;
  logic          w_grow;
  logic          w_scan_last;
  logic          w_seg_hit;

  snake_body_store #(
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H),
    .MAX_LEN (MAX_LEN),
    .XW      (XW),
    .YW      (YW),
    .LW      (LW),
    .IW      (IW)
  ) u_body (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (i_rst),
    .i_push   (w_push),
    .i_push_x (r_nx),
    .i_push_y (r_ny),
    .i_len    (r_len),
    .i_rd_idx (IW'(r_idx)),
    .o_rd_x   (w_rd_x),
    .o_rd_y   (w_rd_y),
    .o_head_x (w_head_x),
    .o_head_y (w_head_y),
    .i_qx     (i_qx),
    .i_qy     (i_qy),
    .o_qhit   (o_qhit),
    .o_qhead  (o_qhead)
  );

  // Direction resolve, candidate head, wall test and food match used by the CALC cycle.
  always_comb begin
    w_dir  = (i_dir == rev_dir(r_dir)) ? r_dir : i_dir;
    w_nx   = w_head_x;
    w_ny   = w_head_y;
    w_wall = 1'b0;
    case (w_dir)
      DIR_UP: begin
        w_wall = (w_head_y == '0);
        w_ny   = w_head_y - 1'b1;
      end
      DIR_DOWN: begin
        w_wall = (w_head_y == YW'(GRID_H - 1));
        w_ny   = w_head_y + 1'b1;
      end
      DIR_LEFT: begin
        w_wall = (w_head_x == '0);
        w_nx   = w_head_x - 1'b1;
      end
      default: begin
        w_wall = (w_head_x == XW'(GRID_W - 1));
        w_nx   = w_head_x + 1'b1;
      end
    endcase
    // A wall move is fatal, so never let its wrapped coordinate count as food.
    w_grow = i_food_valid && !w_wall && (w_nx == i_food_x) && (w_ny == i_food_y);
  end

  // Self-collision compare for the segment currently addressed by the scan; the tail is
  // excluded on non-growing moves because it leaves its cell in the same commit.
  assign w_scan_last = (r_idx == (r_len - 1'b1));
  assign w_seg_hit   = (w_rd_x == r_nx) && (w_rd_y == r_ny) && !(w_scan_last && !r_grow);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and body push strobe; restart forces IDLE and suppresses the push.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          w_state_nxt = r_dead ? ST_FIN : ST_CALC;
        end
      end
      ST_CALC: begin
        w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_scan_last) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_FIN;
        w_push      = !r_dead_pend;
      end
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (i_rst) begin
      w_state_nxt = ST_IDLE;
      w_push      = 1'b0;
    end
  end

  // Step datapath: latch the move in CALC, scan in CHECK, apply results in COMMIT, pulse DONE in FIN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dir       <= DIR_RIGHT;
      r_nx        <= '0;
      r_ny        <= '0;
      r_grow      <= 1'b0;
      r_dead_pend <= 1'b0;
      r_idx       <= '0;
      r_len       <= LW'(INIT_LEN);
      r_score     <= '0;
      r_dead      <= 1'b0;
      r_eat       <= 1'b0;
      r_done      <= 1'b0;
    end else if (i_rst) begin
      r_dir       <= DIR_RIGHT;
      r_nx        <= '0;
      r_ny        <= '0;
      r_grow      <= 1'b0;
      r_dead_pend <= 1'b0;
      r_idx       <= '0;
      r_len       <= LW'(INIT_LEN);
      r_score     <= '0;
      r_dead      <= 1'b0;
      r_eat       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_eat  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_CALC: begin
          r_dir       <= w_dir;
          r_nx        <= w_nx;
          r_ny        <= w_ny;
          r_grow      <= w_grow;
          r_dead_pend <= w_wall;
          r_idx       <= '0;
        end
        ST_CHECK: begin
          if (w_seg_hit) begin
            r_dead_pend <= 1'b1;
          end
          r_idx <= r_idx + 1'b1;
        end
        ST_COMMIT: begin
          if (r_dead_pend) begin
            r_dead <= 1'b1;
          end else if (r_grow) begin
            r_eat <= 1'b1;
            if (r_len != LW'(MAX_LEN)) begin
              r_len <= r_len + 1'b1;
            end
            if (r_score != 8'hFF) begin
              r_score <= r_score + 1'b1;
            end
          end
        end
        ST_FIN: begin
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign o_head_x = w_head_x;
  assign o_head_y = w_head_y;
  assign o_len    = r_len;
  assign o_score  = r_score;
  assign o_dead   = r_dead;
  assign o_eat    = r_eat;
  assign o_done   = r_done;

endmodule
